lag_pl_output_allocator: RTL and testbench

- Per-output-port PL (physical lane) allocator; one instance per router output port.
- Sits between the input-port requesters and that output's PL free pool.
- Each cycle it matches pending requests to PLs the free pool reports as free, with round-robin fairness on both requesters and PLs.
- Drives the free pool's pl_allocated pulse and returns a granted PL id to each winning requester.

---
 rtl/lag_pl_output_allocator_pkg.sv | 24 ++
 rtl/lag_pl_output_allocator_if.sv | 25 ++
 rtl/lag_pl_output_allocator_rr_pick.sv | 29 ++
 rtl/lag_pl_output_allocator.sv | 122 ++++++++++++
 tb/tb_lag_pl_output_allocator.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/lag_pl_output_allocator_pkg.sv
// Shared LAG types and helpers for the per-output PL allocator.
package lag_pl_output_allocator_pkg;

  localparam int unsigned LAG_NUM_INPUTS = 5;
  localparam int unsigned LAG_NUM_PLS    = 4;
  localparam int unsigned LAG_MAX_GRANTS = 4;

  localparam int unsigned LAG_PL_W  = (LAG_NUM_PLS > 1) ? $clog2(LAG_NUM_PLS) : 1;
  localparam int unsigned LAG_REQ_W = (LAG_NUM_INPUTS > 1) ? $clog2(LAG_NUM_INPUTS) : 1;

  typedef logic [LAG_PL_W-1:0]  pl_t;
  typedef logic [LAG_REQ_W-1:0] req_id_t;

  // OR of set-bit positions; exact for a one-hot (or zero) input.
  function automatic int unsigned onehot_to_bin(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/lag_pl_output_allocator_if.sv
// Requester/free-pool side bundle of the PL output allocator.
interface lag_pl_output_allocator_if
  import lag_pl_output_allocator_pkg::*;
#(
  parameter int unsigned num_inputs = LAG_NUM_INPUTS,
  parameter int unsigned num_pls    = LAG_NUM_PLS,
  localparam int unsigned pl_w      = (num_pls > 1) ? $clog2(num_pls) : 1
);
  logic [num_inputs-1:0]      req;
  logic [num_pls-1:0]         pl_alloc_status;
  logic [num_pls-1:0]         pl_allocated;
  logic [num_inputs-1:0]      grant;
  logic [num_inputs*pl_w-1:0] grant_pl;
  logic                       busy;

  modport master (
    output req, pl_alloc_status,
    input  pl_allocated, grant, grant_pl, busy
  );

  modport slave (
    input  req, pl_alloc_status,
    output pl_allocated, grant, grant_pl, busy
  );
endinterface

// File: rtl/lag_pl_output_allocator_rr_pick.sv
// Round-robin first-one finder: first set bit of vec at or after start, wrapping.
module lag_rr_pick
  import lag_pl_output_allocator_pkg::*;
#(
  parameter int unsigned width  = 4,
  localparam int unsigned idx_w = (width > 1) ? $clog2(width) : 1
) (
  input  logic [width-1:0] vec,
  input  logic [idx_w-1:0] start,
  output logic [width-1:0] onehot,
  output logic [idx_w-1:0] idx,
  output logic             found
);

  always_comb begin
    onehot = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < width; k++) begin
      int unsigned pos;
      pos = (32'(start) + k) % width;
      if (!found && vec[pos]) begin
        onehot[pos] = 1'b1;
        found       = 1'b1;
      end
    end
    idx = idx_w'(onehot_to_bin(32'(onehot)));
  end

endmodule

// File: rtl/lag_pl_output_allocator.sv
// Per-output-port PL allocator: matches requesters to free PLs, round-robin on both sides.
module lag_pl_output_allocator
  import lag_pl_output_allocator_pkg::*;
#(
  parameter int unsigned num_inputs = LAG_NUM_INPUTS,
  parameter int unsigned num_pls    = LAG_NUM_PLS,
  parameter int unsigned max_grants = LAG_MAX_GRANTS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  lag_pl_output_allocator_if.slave  bus
);

  localparam int unsigned pl_w = (num_pls > 1) ? $clog2(num_pls) : 1;
  localparam int unsigned rw   = (num_inputs > 1) ? $clog2(num_inputs) : 1;

  logic [num_inputs-1:0]      grant_q, grant_d;
  logic [num_inputs*pl_w-1:0] grant_pl_q, grant_pl_d;
  logic [num_pls-1:0]         pl_allocated_q, pl_allocated_d;
  logic                       busy_q, busy_d;
  logic [rw-1:0]              req_ptr_q, req_ptr_d;
  logic [pl_w-1:0]            pl_ptr_q, pl_ptr_d;

  logic [num_inputs-1:0] req_elig;
  logic [num_pls-1:0]    pl_elig;

  // Outputs still on the wires are in flight: the requester and pool react one cycle late.
  assign req_elig = bus.req & ~grant_q;
  assign pl_elig  = bus.pl_alloc_status & ~pl_allocated_q;

  logic [max_grants-1:0]                 hit_v;
  logic [max_grants-1:0][num_inputs-1:0] roh_v;
  logic [max_grants-1:0][rw-1:0]         ridx_v;
  logic [max_grants-1:0][num_pls-1:0]    poh_v;
  logic [max_grants-1:0][pl_w-1:0]       pidx_v;

  // Both pickers keep the registered start; masking winners yields the next in RR order.
  for (genvar g = 0; g < int'(max_grants); g++) begin : gen_pass
    logic [num_inputs-1:0] r_in, r_out, r_oh;
    logic [num_pls-1:0]    p_in, p_out, p_oh;
    logic [rw-1:0]         r_idx;
    logic [pl_w-1:0]       p_idx;
    logic                  r_found, p_found, hit;

    if (g == 0) begin : gen_head
      assign r_in = req_elig;
      assign p_in = pl_elig;
    end else begin : gen_chain
      assign r_in = gen_pass[g-1].r_out;
      assign p_in = gen_pass[g-1].p_out;
    end

    lag_rr_pick #(.width(num_inputs)) u_req_pick (
      .vec(r_in), .start(req_ptr_q), .onehot(r_oh), .idx(r_idx), .found(r_found)
    );

    lag_rr_pick #(.width(num_pls)) u_pl_pick (
      .vec(p_in), .start(pl_ptr_q), .onehot(p_oh), .idx(p_idx), .found(p_found)
    );

    assign hit   = r_found & p_found;
    assign r_out = hit ? (r_in & ~r_oh) : r_in;
    assign p_out = hit ? (p_in & ~p_oh) : p_in;

    assign hit_v[g]  = hit;
    assign roh_v[g]  = r_oh;
    assign ridx_v[g] = r_idx;
    assign poh_v[g]  = p_oh;
    assign pidx_v[g] = p_idx;
  end

  always_comb begin
    int unsigned n_elig;
    int unsigned n_grants;
    grant_d        = '0;
    grant_pl_d     = '0;
    pl_allocated_d = '0;
    req_ptr_d      = req_ptr_q;
    pl_ptr_d       = pl_ptr_q;
    n_elig         = 0;
    n_grants       = 0;
    for (int unsigned g = 0; g < max_grants; g++) begin
      if (hit_v[g]) begin
        grant_d        = grant_d | roh_v[g];
        pl_allocated_d = pl_allocated_d | poh_v[g];
        grant_pl_d[32'(ridx_v[g])*pl_w +: pl_w] = pidx_v[g];
        n_grants       = n_grants + 1;
        req_ptr_d = (32'(ridx_v[g]) == num_inputs - 1) ? '0 : ridx_v[g] + rw'(1);
        pl_ptr_d  = (32'(pidx_v[g]) == num_pls - 1) ? '0 : pidx_v[g] + pl_w'(1);
      end
    end
    for (int unsigned i = 0; i < num_inputs; i++) begin
      n_elig = n_elig + 32'(req_elig[i]);
    end
    busy_d = (n_elig > n_grants);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q        <= '0;
      grant_pl_q     <= '0;
      pl_allocated_q <= '0;
      busy_q         <= 1'b0;
      req_ptr_q      <= '0;
      pl_ptr_q       <= '0;
    end else begin
      assert ((pl_allocated_d & ~bus.pl_alloc_status) == '0);
      grant_q        <= grant_d;
      grant_pl_q     <= grant_pl_d;
      pl_allocated_q <= pl_allocated_d;
      busy_q         <= busy_d;
      req_ptr_q      <= req_ptr_d;
      pl_ptr_q       <= pl_ptr_d;
    end
  end

  assign bus.grant        = grant_q;
  assign bus.grant_pl     = grant_pl_q;
  assign bus.pl_allocated = pl_allocated_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_lag_pl_output_allocator.sv
// Scoreboard bench for lag_pl_output_allocator: directed vectors on a max_grants=4 and a max_grants=1 instance.
module tb_lag_pl_output_allocator;
  import lag_pl_output_allocator_pkg::*;

  localparam int unsigned NI = 5;
  localparam int unsigned NP = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lag_pl_output_allocator_if #(.num_inputs(NI), .num_pls(NP)) if0 ();
  lag_pl_output_allocator_if #(.num_inputs(NI), .num_pls(NP)) if1 ();

  lag_pl_output_allocator #(.num_inputs(NI), .num_pls(NP), .max_grants(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );

  lag_pl_output_allocator #(.num_inputs(NI), .num_pls(NP), .max_grants(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  typedef struct {
    int unsigned    due;
    string          tag;
    logic [NI-1:0]  grant;
    logic [9:0]     gpl;
    logic [NP-1:0]  pl;
    logic           busy;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [NI-1:0] req0_s, req1_s;
  logic [NP-1:0] st0_s, st1_s;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    req0_s <= if0.req;
    st0_s  <= if0.pl_alloc_status;
    req1_s <= if1.req;
    st1_s  <= if1.pl_alloc_status;
  end

  function automatic logic [9:0] pid(input int unsigned i, input pl_t id);
    return 10'(id) << (2 * i);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic score(input exp_t e, input logic [NI-1:0] g, input logic [9:0] gp,
                       input logic [NP-1:0] pl, input logic b);
    check({e.tag, ".grant"},        32'(g),  32'(e.grant));
    check({e.tag, ".grant_pl"},     32'(gp), 32'(e.gpl));
    check({e.tag, ".pl_allocated"}, 32'(pl), 32'(e.pl));
    check({e.tag, ".busy"},         32'(b),  32'(e.busy));
  endtask

  task automatic push(input int unsigned inst, input logic [NI-1:0] eg, input logic [9:0] egpl,
                      input logic [NP-1:0] epl, input logic eb, input string tag);
    exp_t e;
    e.due = cyc + 1; e.tag = tag; e.grant = eg; e.gpl = egpl; e.pl = epl; e.busy = eb;
    if (inst == 0) q0.push_back(e);
    else           q1.push_back(e);
  endtask

  task automatic apply(input int unsigned inst, input logic [NI-1:0] r, input logic [NP-1:0] s,
                       input logic [NI-1:0] eg, input logic [9:0] egpl, input logic [NP-1:0] epl,
                       input logic eb, input string tag);
    @(posedge clk);
    #1;
    if (inst == 0) begin
      if0.req = r; if0.pl_alloc_status = s;
    end else begin
      if1.req = r; if1.pl_alloc_status = s;
    end
    push(inst, eg, egpl, epl, eb, tag);
  endtask

  // Monitor: invariants every cycle, scoreboard pops when an expectation falls due.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("inv0_grant_in_req", 32'(if0.grant & ~req0_s), 32'd0);
        check("inv0_pl_in_status", 32'(if0.pl_allocated & ~st0_s), 32'd0);
        check("inv0_popcount", 32'($countones(if0.pl_allocated)), 32'($countones(if0.grant)));
        check("inv1_grant_in_req", 32'(if1.grant & ~req1_s), 32'd0);
        check("inv1_popcount", 32'($countones(if1.pl_allocated)), 32'($countones(if1.grant)));
      end
      while (q0.size() != 0 && q0[0].due <= cyc) begin
        e = q0.pop_front();
        if (e.due != cyc) check({e.tag, ".stale"}, 32'(e.due), 32'(cyc));
        else score(e, if0.grant, if0.grant_pl, if0.pl_allocated, if0.busy);
      end
      while (q1.size() != 0 && q1[0].due <= cyc) begin
        e = q1.pop_front();
        if (e.due != cyc) check({e.tag, ".stale"}, 32'(e.due), 32'(cyc));
        else score(e, if1.grant, if1.grant_pl, if1.pl_allocated, if1.busy);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    if0.req = '0; if0.pl_alloc_status = '0;
    if1.req = '0; if1.pl_alloc_status = '0;
    #3;
    check("reset_outputs", 32'({if0.grant, if0.grant_pl, if0.pl_allocated, if0.busy}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Five requesters, four free PLs: four grants, requester 4 left waiting.
    apply(0, 5'b11111, 4'b1111, 5'b01111, pid(0,0)|pid(1,1)|pid(2,2)|pid(3,3), 4'b1111, 1'b1, "all_free");

    // Asynchronous reset in mid-cycle with requests held.
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midrst_outputs", 32'({if0.grant, if0.grant_pl, if0.pl_allocated, if0.busy}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    push(0, 5'b01111, pid(0,0)|pid(1,1)|pid(2,2)|pid(3,3), 4'b1111, 1'b1, "post_rst");

    apply(0, 5'b10000, 4'b1111, 5'b00000, 10'd0, 4'b0000, 1'b1, "inflight_all");
    apply(0, 5'b00101, 4'b0000, 5'b00000, 10'd0, 4'b0000, 1'b1, "nofree_a");
    apply(0, 5'b00101, 4'b0000, 5'b00000, 10'd0, 4'b0000, 1'b1, "nofree_b");
    apply(0, 5'b00101, 4'b0100, 5'b00001, pid(0,2), 4'b0100, 1'b1, "freed_pl2");
    apply(0, 5'b00100, 4'b0100, 5'b00000, 10'd0, 4'b0000, 1'b1, "pl2_masked");
    apply(0, 5'b00000, 4'b0000, 5'b00000, 10'd0, 4'b0000, 1'b0, "withdraw");
    apply(0, 5'b00011, 4'b0001, 5'b00010, pid(1,0), 4'b0001, 1'b1, "inflight_a");
    apply(0, 5'b00011, 4'b0001, 5'b00000, 10'd0, 4'b0000, 1'b1, "inflight_b");
    apply(0, 5'b00001, 4'b0000, 5'b00000, 10'd0, 4'b0000, 1'b1, "starved");
    apply(0, 5'b01001, 4'b0100, 5'b01000, pid(3,2), 4'b0100, 1'b1, "same_cycle_free");
    apply(0, 5'b00001, 4'b0100, 5'b00000, 10'd0, 4'b0000, 1'b1, "pl2_masked2");
    apply(0, 5'b10001, 4'b1001, 5'b10001, pid(4,3)|pid(0,0), 4'b1001, 1'b0, "wrap");
    apply(0, 5'b00000, 4'b1001, 5'b00000, 10'd0, 4'b0000, 1'b0, "idle");
    apply(0, 5'b00011, 4'b0110, 5'b00011, pid(1,1)|pid(0,2), 4'b0110, 1'b0, "post_wrap_ptrs");
    apply(0, 5'b00000, 4'b0000, 5'b00000, 10'd0, 4'b0000, 1'b0, "idle2");

    // Single-grant instance: requesters and PLs both rotate.
    apply(1, 5'b11111, 4'b1111, 5'b00001, pid(0,0), 4'b0001, 1'b1, "rr0");
    apply(1, 5'b11111, 4'b1111, 5'b00010, pid(1,1), 4'b0010, 1'b1, "rr1");
    apply(1, 5'b11111, 4'b1111, 5'b00100, pid(2,2), 4'b0100, 1'b1, "rr2");
    apply(1, 5'b11111, 4'b1111, 5'b01000, pid(3,3), 4'b1000, 1'b1, "rr3");
    apply(1, 5'b11111, 4'b1111, 5'b10000, pid(4,0), 4'b0001, 1'b1, "rr4");
    apply(1, 5'b11111, 4'b1111, 5'b00001, pid(0,1), 4'b0010, 1'b1, "rr5");
    apply(1, 5'b00000, 4'b1111, 5'b00000, 10'd0, 4'b0000, 1'b0, "rr_idle");

    // Random traffic on the wide instance; only the invariants judge it.
    for (int k = 0; k < 150; k++) begin
      @(posedge clk);
      #1;
      if0.req = 5'($urandom);
      if0.pl_alloc_status = 4'($urandom);
    end
    @(posedge clk);
    #1;
    if0.req = '0;
    if0.pl_alloc_status = '0;

    for (int k = 0; k < 20 && (q0.size() != 0 || q1.size() != 0); k++) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
